// File: rtl/intersection_controller.sv
// Two-approach intersection sequencer with optional protected left-turn
// phases, fixed per-state dwell times and an emergency all-red hold.
//
// state    | meaning
// CLR_NS   | all red, clearance before the NS approach is served
// NS_LEFT  | NS protected left arrow
// NS_GREEN | NS green
// NS_YEL   | NS yellow
// CLR_EW   | all red, clearance before the EW approach is served
// EW_LEFT  | EW protected left arrow
// EW_GREEN | EW green
// EW_YEL   | EW yellow
// EMERG    | all red, held while emergency is asserted
module intersection_controller #(
    parameter int unsigned T_LEFT  = 5,
    parameter int unsigned T_GREEN = 10,
    parameter int unsigned T_YEL   = 3,
    parameter int unsigned T_CLR   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       emergency,
    input  logic       left_req_ns,
    input  logic       left_req_ew,
    output logic [3:0] ns_out,
    output logic [3:0] ew_out,
    output logic [3:0] phase,
    output logic       emerg_active
);

    typedef enum logic [3:0] {
        CLR_NS   = 4'd0,
        NS_LEFT  = 4'd1,
        NS_GREEN = 4'd2,
        NS_YEL   = 4'd3,
        CLR_EW   = 4'd4,
        EW_LEFT  = 4'd5,
        EW_GREEN = 4'd6,
        EW_YEL   = 4'd7,
        EMERG    = 4'd8
    } state_t;

    localparam logic [3:0] LAMP_ARROW = 4'b1001;
    localparam logic [3:0] LAMP_GREEN = 4'b0100;
    localparam logic [3:0] LAMP_YEL   = 4'b0010;
    localparam logic [3:0] LAMP_RED   = 4'b0001;

    // Counter value on the final cycle of each state.
    localparam logic [4:0] LAST_LEFT  = 5'(T_LEFT - 1);
    localparam logic [4:0] LAST_GREEN = 5'(T_GREEN - 1);
    localparam logic [4:0] LAST_YEL   = 5'(T_YEL - 1);
    localparam logic [4:0] LAST_CLR   = 5'(T_CLR - 1);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       ns_pend_q, ns_pend_d;
    logic       ew_pend_q, ew_pend_d;
    logic       last_ew_q, last_ew_d;
    logic       emerg_pend_q, emerg_pend_d;
    logic [3:0] ns_out_q, ew_out_q, phase_q;
    logic       emerg_q;
    logic [7:0] lamps_d;

    // Lamp pair {ns, ew} shown in a given state; at most one approach is non-red.
    function automatic logic [7:0] lamps(state_t s);
        case (s)
            NS_LEFT:  return {LAMP_ARROW, LAMP_RED};
            NS_GREEN: return {LAMP_GREEN, LAMP_RED};
            NS_YEL:   return {LAMP_YEL,   LAMP_RED};
            EW_LEFT:  return {LAMP_RED, LAMP_ARROW};
            EW_GREEN: return {LAMP_RED, LAMP_GREEN};
            EW_YEL:   return {LAMP_RED, LAMP_YEL};
            default:  return {LAMP_RED, LAMP_RED};
        endcase
    endfunction

    // Next-state, dwell counter and side-flag logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLR_NS:   if (emergency) state_d = EMERG;
                      else if (cnt_q == LAST_CLR) state_d = ns_pend_q ? NS_LEFT : NS_GREEN;
            NS_LEFT:  if (emergency) state_d = NS_YEL;
                      else if (cnt_q == LAST_LEFT) state_d = NS_GREEN;
            NS_GREEN: if (emergency || cnt_q == LAST_GREEN) state_d = NS_YEL;
            NS_YEL:   if (cnt_q == LAST_YEL) state_d = (emerg_pend_q || emergency) ? EMERG : CLR_EW;
            CLR_EW:   if (emergency) state_d = EMERG;
                      else if (cnt_q == LAST_CLR) state_d = ew_pend_q ? EW_LEFT : EW_GREEN;
            EW_LEFT:  if (emergency) state_d = EW_YEL;
                      else if (cnt_q == LAST_LEFT) state_d = EW_GREEN;
            EW_GREEN: if (emergency || cnt_q == LAST_GREEN) state_d = EW_YEL;
            EW_YEL:   if (cnt_q == LAST_YEL) state_d = (emerg_pend_q || emergency) ? EMERG : CLR_NS;
            EMERG:    if (!emergency) state_d = last_ew_q ? CLR_NS : CLR_EW;
            default:  state_d = CLR_NS;
        endcase

        cnt_d = (state_d != state_q) ? 5'd0 : cnt_q + 5'd1;

        // A request seen during its own left phase counts as already served.
        ns_pend_d = (state_q == NS_LEFT) ? 1'b0 : (ns_pend_q | left_req_ns);
        ew_pend_d = (state_q == EW_LEFT) ? 1'b0 : (ew_pend_q | left_req_ew);

        last_ew_d = last_ew_q;
        if (state_d != state_q) begin
            if (state_d == EW_LEFT || state_d == EW_GREEN) last_ew_d = 1'b1;
            if (state_d == NS_LEFT || state_d == NS_GREEN) last_ew_d = 1'b0;
        end

        // Remembers an emergency seen while an approach is lit so that a
        // request dropped during the forced yellow still ends in EMERG.
        emerg_pend_d = emerg_pend_q;
        if (state_d == EMERG && state_q != EMERG)
            emerg_pend_d = 1'b0;
        else if (emergency && (state_q == NS_LEFT || state_q == NS_GREEN || state_q == NS_YEL ||
                               state_q == EW_LEFT || state_q == EW_GREEN || state_q == EW_YEL))
            emerg_pend_d = 1'b1;

        lamps_d = lamps(state_d);
    end

    // State, flags and outputs all update on the same edge; outputs are
    // registered copies of the decode of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CLR_NS;
            cnt_q        <= 5'd0;
            ns_pend_q    <= 1'b0;
            ew_pend_q    <= 1'b0;
            last_ew_q    <= 1'b1;
            emerg_pend_q <= 1'b0;
            ns_out_q     <= LAMP_RED;
            ew_out_q     <= LAMP_RED;
            phase_q      <= 4'd0;
            emerg_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ns_pend_q    <= ns_pend_d;
            ew_pend_q    <= ew_pend_d;
            last_ew_q    <= last_ew_d;
            emerg_pend_q <= emerg_pend_d;
            ns_out_q     <= lamps_d[7:4];
            ew_out_q     <= lamps_d[3:0];
            phase_q      <= state_d;
            emerg_q      <= (state_d == EMERG);
        end
    end

    assign ns_out       = ns_out_q;
    assign ew_out       = ew_out_q;
    assign phase        = phase_q;
    assign emerg_active = emerg_q;

endmodule

// File: doc/intersection_controller.md
INTERSECTION_CONTROLLER -- requirements
Module: intersection_controller

Interface
REQ-001 Parameters SHALL be: T_LEFT, default 5, left-arrow phase length in cycles; T_GREEN, default 10, green length; T_YEL, default 3, yellow length; T_CLR, default 2, all-red clearance length; all legal in 1..31.
REQ-002 Ports SHALL be (clock and reset first): clk  in  1  system clock; rst_n  in  1  reset.
REQ-003 One clock (clk); reset rst_n is asynchronous and active-low.
REQ-004 emergency  in  1  level request for all-red hold, sampled on posedge clk.
REQ-005 left_req_ns  in  1  NS left-turn demand, pulse or level.
REQ-006 left_req_ew  in  1  EW left-turn demand, pulse or level.
REQ-007 ns_out  out  4  NS lamp code: 1001 left arrow, 0100 green, 0010 yellow, 0001 red.
REQ-008 ew_out  out  4  EW lamp code, same encoding.
REQ-009 phase  out  4  current state code per REQ-011.
REQ-010 emerg_active  out  1  high exactly while state is EMERG.

Function
REQ-011 States and codes SHALL be: CLR_NS 0, NS_LEFT 1, NS_GREEN 2, NS_YEL 3, CLR_EW 4, EW_LEFT 5, EW_GREEN 6, EW_YEL 7, EMERG 8; codes 9-15 unreachable and SHALL recover to CLR_NS.
REQ-012 A 5-bit dwell counter SHALL be 0 on entry to every state, increment each cycle, and the state SHALL exit on the cycle the counter equals its T-1, so each state lasts exactly T cycles.
REQ-013 Normal sequence: CLR_NS -> (NS_LEFT if ns_pend else NS_GREEN) -> NS_GREEN -> NS_YEL -> CLR_EW -> (EW_LEFT if ew_pend else EW_GREEN) -> EW_GREEN -> EW_YEL -> CLR_NS.
REQ-014 Dwell: NS_LEFT/EW_LEFT T_LEFT, *_GREEN T_GREEN, *_YEL T_YEL, CLR_* T_CLR.
REQ-015 Lamps: the served approach shows its phase code; the other approach and both approaches in CLR_*/EMERG show 0001; both approaches SHALL never be non-red in the same cycle.
REQ-016 ns_pend SHALL set on any cycle left_req_ns=1 while state!=NS_LEFT, and clear on every cycle in NS_LEFT; ew_pend identically for EW; requests during own left phase are treated as served.
REQ-017 Outputs SHALL be decoded from the state register only and change on the same edge as state.
REQ-018 Emergency in *_LEFT or *_GREEN: next state SHALL be that approach's *_YEL with counter 0 (full yellow).
REQ-019 Emergency in *_YEL: yellow SHALL complete its full dwell, then go to EMERG instead of CLR_*.
REQ-020 Emergency in CLR_*: next state SHALL be EMERG.
REQ-021 EMERG SHALL hold while emergency=1; on first cycle emergency=0, go to the CLR_* for the approach not served last (last_ew flag, set on entering EW_LEFT/EW_GREEN, cleared on entering NS_LEFT/NS_GREEN), serving the opposite approach next.
REQ-022 emergency deasserting during a yellow that was forced by it SHALL NOT cancel the pending EMERG; one pending flag captures it and clears on entry to EMERG.

Reset
REQ-023 While rst_n=0: state CLR_NS, counter 0, ns_pend=ew_pend=0, last_ew=1, EMERG pending flag 0, ns_out=ew_out=0001, phase=0, emerg_active=0.
REQ-024 After reset release the sequence SHALL begin with full T_CLR in CLR_NS; reset asserted mid-phase SHALL take effect immediately, without waiting for a clock edge.

Verification
REQ-025 Defaults, no requests: release reset -> CLR_NS cycles 0-1, NS_GREEN 2-11, NS_YEL 12-14, CLR_EW 15-16, EW_GREEN 17-26, EW_YEL 27-29, CLR_NS at 30.
REQ-026 Pulse left_req_ew at cycle 5 -> EW_LEFT ew_out=1001 cycles 17-21, EW_GREEN 22-31, ew_pend=0 after cycle 17.
REQ-027 emergency=1 at NS_GREEN counter 4 -> NS_YEL 3 cycles, EMERG, both 0001, emerg_active=1; drop emergency -> CLR_EW then EW_GREEN.
REQ-028 One-cycle emergency pulse in NS_YEL counter 0 -> yellow completes, EMERG 1 cycle, CLR_EW.
REQ-029 rst_n low mid EW_GREEN -> outputs immediately 0001/0001, phase 0; release -> REQ-025 timeline.
REQ-030 Every cycle, all tests: ns_out and ew_out never both non-0001; phase never 9-15.
